// File: rtl/arb_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | arb_pkg : shared types and sizes for the memory arbiter               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package arb_pkg;

  localparam int NUM_REQ   = 2;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int BMASK_W   = DATA_W / 8;
  localparam int REQ_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RSP    = 2'd2
  } arb_state_e;

  // Reads always fetch the whole word, so only writes carry the requester mask.
  function automatic logic [BMASK_W-1:0] access_bmask(input logic                we,
                                                      input logic [BMASK_W-1:0] bmask);
    return we ? bmask : {BMASK_W{1'b1}};
  endfunction

  function automatic logic [REQ_IDX_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [REQ_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = REQ_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | mem_arbiter_if : requester and memory-side bus of the arbiter         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface mem_arbiter_if;
  import arb_pkg::*;

  logic [NUM_REQ-1:0]              i_req;
  logic [NUM_REQ-1:0]              i_we;
  logic [NUM_REQ-1:0][ADDR_W-1:0]  i_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0]  i_wdata;
  logic [NUM_REQ-1:0][BMASK_W-1:0] i_bmask;
  logic [NUM_REQ-1:0]              o_gnt;
  logic [NUM_REQ-1:0]              o_rvalid;
  logic [DATA_W-1:0]               o_rdata;
  logic                            o_mem_en;
  logic                            o_mem_we;
  logic [ADDR_W-1:0]               o_mem_addr;
  logic [DATA_W-1:0]               o_mem_wdata;
  logic [BMASK_W-1:0]              o_mem_bmask;
  logic [DATA_W-1:0]               i_mem_rdata;
  logic                            o_busy;

  modport slave (
    input  i_req, i_we, i_addr, i_wdata, i_bmask, i_mem_rdata,
    output o_gnt, o_rvalid, o_rdata, o_mem_en, o_mem_we, o_mem_addr,
           o_mem_wdata, o_mem_bmask, o_busy
  );

  modport master (
    output i_req, i_we, i_addr, i_wdata, i_bmask, i_mem_rdata,
    input  o_gnt, o_rvalid, o_rdata, o_mem_en, o_mem_we, o_mem_addr,
           o_mem_wdata, o_mem_bmask, o_busy
  );

endinterface
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | rr_picker : combinational round-robin winner select (one-hot out)     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_picker
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [REQ_IDX_W-1:0] i_last,
  output logic [NUM_REQ-1:0]   o_winner
);

  logic                 found;
  logic [REQ_IDX_W-1:0] idx;

  // Search starts just after the last winner, so it gets lowest priority.
  always_comb begin
    o_winner = '0;
    found    = 1'b0;
    idx      = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = REQ_IDX_W'((int'(i_last) + off) % NUM_REQ);
      if (!found && i_req[idx]) begin
        o_winner[idx] = 1'b1;
        found         = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | mem_arbiter : round-robin arbiter of LSU and loader onto one memory   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mem_arbiter
  import arb_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst_n,
  mem_arbiter_if.slave bus
);

  arb_state_e           state_q,  state_d;
  logic [REQ_IDX_W-1:0] last_q,   last_d;
  logic [NUM_REQ-1:0]   winner_q, winner_d;
  logic                 we_q,     we_d;
  logic [ADDR_W-1:0]    addr_q,   addr_d;
  logic [DATA_W-1:0]    wdata_q,  wdata_d;
  logic [BMASK_W-1:0]   bmask_q,  bmask_d;

  logic [NUM_REQ-1:0]   pick;
  logic                 sel_we;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata;
  logic [BMASK_W-1:0]   sel_bmask;

  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   rvalid;
  logic [DATA_W-1:0]    rdata;
  logic                 mem_en;
  logic                 mem_we;
  logic [ADDR_W-1:0]    mem_addr;
  logic [DATA_W-1:0]    mem_wdata;
  logic [BMASK_W-1:0]   mem_bmask;
  logic                 busy;

  rr_picker u_picker (
    .i_req    (bus.i_req),
    .i_last   (last_q),
    .o_winner (pick)
  );

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_bmask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) begin
        sel_we    = bus.i_we[i];
        sel_addr  = bus.i_addr[i];
        sel_wdata = bus.i_wdata[i];
        sel_bmask = bus.i_bmask[i];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      last_q   <= REQ_IDX_W'(NUM_REQ - 1);
      winner_q <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      bmask_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      winner_q <= winner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      bmask_q  <= bmask_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    winner_d  = winner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    bmask_d   = bmask_q;
    gnt       = '0;
    rvalid    = '0;
    rdata     = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_bmask = '0;
    busy      = (state_q != ST_IDLE);

    unique case (state_q)
      ST_IDLE: begin
        // Payload is captured here so later requester changes cannot leak in.
        if (|bus.i_req) begin
          state_d  = ST_ACCESS;
          winner_d = pick;
          we_d     = sel_we;
          addr_d   = sel_addr;
          wdata_d  = sel_wdata;
          bmask_d  = access_bmask(sel_we, sel_bmask);
        end
      end
      ST_ACCESS: begin
        gnt       = winner_q;
        mem_en    = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_bmask = bmask_q;
        last_d    = onehot_to_idx(winner_q);
        state_d   = we_q ? ST_IDLE : ST_RSP;
      end
      ST_RSP: begin
        rvalid  = winner_q;
        rdata   = bus.i_mem_rdata;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.o_gnt       = gnt;
  assign bus.o_rvalid    = rvalid;
  assign bus.o_rdata     = rdata;
  assign bus.o_mem_en    = mem_en;
  assign bus.o_mem_we    = mem_we;
  assign bus.o_mem_addr  = mem_addr;
  assign bus.o_mem_wdata = mem_wdata;
  assign bus.o_mem_bmask = mem_bmask;
  assign bus.o_busy      = busy;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_mem_arbiter : scoreboard bench with cycle-level reference model    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mem_arbiter;
  import arb_pkg::*;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int          cyc;
    logic [1:0]  gnt;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  bm;
  } gnt_exp_t;

  typedef struct {
    int          cyc;
    logic [1:0]  rv;
    logic [31:0] rdata;
  } rv_exp_t;

  gnt_exp_t gq[$];
  rv_exp_t  rq[$];
  gnt_exp_t ge;
  rv_exp_t  re;

  int n_tests = 0;
  int n_fail  = 0;
  int ncyc    = 0;

  always @(posedge i_clk) ncyc <= ncyc + 1;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] bm);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (bm[b]) r[8*b +: 8] = nw[8*b +: 8];
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, ncyc);
    end
  endtask

  // Memory attached to the arbiter; unwritten words read back as ~address.
  logic [31:0] emem [256];
  bit          ewr  [256];
  logic [31:0] e_rdata;
  logic [7:0]  e_ix;

  assign e_ix            = bus.o_mem_addr[9:2];
  assign bus.i_mem_rdata = e_rdata;

  always @(posedge i_clk) begin
    if (bus.o_mem_en) begin
      if (bus.o_mem_we) begin
        emem[e_ix] <= merge(ewr[e_ix] ? emem[e_ix] : ~bus.o_mem_addr,
                            bus.o_mem_wdata, bus.o_mem_bmask);
        ewr[e_ix]  <= 1'b1;
      end else begin
        e_rdata <= ewr[e_ix] ? emem[e_ix] : ~bus.o_mem_addr;
      end
    end
  end

  // Monitor: compares whatever the DUT presents against the scoreboard queues.
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      chk("rst_ctrl_zero", 32'({bus.o_gnt, bus.o_rvalid, bus.o_mem_en, bus.o_mem_we,
                                bus.o_busy, bus.o_mem_bmask}), 32'h0);
      chk("rst_mem_addr_zero", bus.o_mem_addr, 32'h0);
    end else begin
      chk("gnt_onehot",    32'($countones(bus.o_gnt) <= 1), 32'h1);
      chk("rvalid_onehot", 32'($countones(bus.o_rvalid) <= 1), 32'h1);
      chk("busy", 32'(bus.o_busy), 32'((|bus.o_gnt) || (|bus.o_rvalid)));

      if (bus.o_gnt != 2'b00) begin
        if (gq.size() == 0) begin
          chk("gnt_unexpected", 32'(bus.o_gnt), 32'h0);
        end else begin
          ge = gq.pop_front();
          chk("gnt_cycle",  32'(ncyc), 32'(ge.cyc));
          chk("gnt_vec",    32'(bus.o_gnt), 32'(ge.gnt));
          chk("mem_en",     32'(bus.o_mem_en), 32'h1);
          chk("mem_we",     32'(bus.o_mem_we), 32'(ge.we));
          chk("mem_addr",   bus.o_mem_addr, ge.addr);
          chk("mem_bmask",  32'(bus.o_mem_bmask), 32'(ge.bm));
          if (ge.we) chk("mem_wdata", bus.o_mem_wdata, ge.wdata);
        end
      end else begin
        chk("mem_en_we_idle", 32'({bus.o_mem_en, bus.o_mem_we}), 32'h0);
        if (gq.size() > 0 && gq[0].cyc <= ncyc) begin
          chk("gnt_missing", 32'(bus.o_gnt), 32'(gq[0].gnt));
          void'(gq.pop_front());
        end
      end

      if (bus.o_rvalid != 2'b00) begin
        if (rq.size() == 0) begin
          chk("rvalid_unexpected", 32'(bus.o_rvalid), 32'h0);
        end else begin
          re = rq.pop_front();
          chk("rvalid_cycle", 32'(ncyc), 32'(re.cyc));
          chk("rvalid_vec",   32'(bus.o_rvalid), 32'(re.rv));
          chk("rdata",        bus.o_rdata, re.rdata);
        end
      end else if (rq.size() > 0 && rq[0].cyc <= ncyc) begin
        chk("rvalid_missing", 32'(bus.o_rvalid), 32'(rq[0].rv));
        void'(rq.pop_front());
      end
    end
  end

  // Reference model: arbiter is free again 2 cycles after a write sample,
  // 3 after a read; ties go to whoever was not granted last.
  bit          pend  [2];
  logic        we_r  [2];
  logic [31:0] addr_r[2];
  logic [31:0] wd_r  [2];
  logic [3:0]  bm_r  [2];
  logic [31:0] mmem  [256];
  bit          mwr   [256];
  int          last_g  = 1;
  int          free_at = 0;
  bit          rnd     = 1'b0;

  task automatic new_txn(input int i, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] bm);
    pend[i]   = 1'b1;
    we_r[i]   = we;
    addr_r[i] = a;
    wd_r[i]   = d;
    bm_r[i]   = bm;
  endtask

  task automatic step();
    int          p;
    int          w;
    logic [7:0]  ix;
    p = ncyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (rnd && !pend[i] && $urandom_range(0, 1) == 1)
        new_txn(i, 1'($urandom_range(0, 1)), 32'h100 + 32'(4 * $urandom_range(0, 7)),
                $urandom, 4'($urandom_range(1, 15)));
    end
    for (int i = 0; i < 2; i++) begin
      // Non-pending requesters may flash a request while the arbiter is busy.
      bus.i_req[i] = pend[i] || (rnd && p < free_at && $urandom_range(0, 3) == 0);
      if (pend[i]) begin
        bus.i_we[i]    = we_r[i];
        bus.i_addr[i]  = addr_r[i];
        bus.i_wdata[i] = wd_r[i];
        bus.i_bmask[i] = bm_r[i];
      end else begin
        bus.i_we[i]    = 1'($urandom_range(0, 1));
        bus.i_addr[i]  = $urandom;
        bus.i_wdata[i] = $urandom;
        bus.i_bmask[i] = 4'($urandom_range(0, 15));
      end
    end
    if (p >= free_at && (pend[0] || pend[1])) begin
      w  = (pend[0] && pend[1]) ? 1 - last_g : (pend[0] ? 0 : 1);
      ix = addr_r[w][9:2];
      gq.push_back('{p, 2'(1 << w), we_r[w], addr_r[w], wd_r[w],
                     we_r[w] ? bm_r[w] : 4'hF});
      if (we_r[w]) begin
        mmem[ix] = merge(mwr[ix] ? mmem[ix] : ~addr_r[w], wd_r[w], bm_r[w]);
        mwr[ix]  = 1'b1;
        free_at  = p + 2;
      end else begin
        rq.push_back('{p + 1, 2'(1 << w), mwr[ix] ? mmem[ix] : ~addr_r[w]});
        free_at = p + 3;
      end
      last_g  = w;
      pend[w] = 1'b0;
    end
    @(posedge i_clk);
    @(negedge i_clk);
    #1;
  endtask

  task automatic drain();
    repeat (10) step();
  endtask

  initial begin
    bus.i_req   = '0;
    bus.i_we    = '0;
    bus.i_addr  = '0;
    bus.i_wdata = '0;
    bus.i_bmask = '0;
    repeat (3) @(negedge i_clk);
    #1;
    i_rst_n = 1'b1;

    // Continuous tie of reads straight after reset: m0 first, then alternate.
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < 2; i++)
        if (!pend[i]) new_txn(i, 1'b0, 32'h180 + 32'(4 * i), 32'h0, 4'h0);
      step();
    end
    drain();

    new_txn(0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
    drain();
    new_txn(1, 1'b0, 32'h100, 32'h0, 4'h3);
    drain();

    // Payload swapped right after sampling must not reach the memory bus.
    new_txn(0, 1'b1, 32'h200, 32'h11223344, 4'hF);
    step();
    bus.i_req[0]  = 1'b1;
    bus.i_addr[0] = 32'h300;
    @(posedge i_clk);
    @(negedge i_clk);
    #1;
    drain();

    new_txn(0, 1'b1, 32'h104, 32'hA5A5A5A5, 4'b0011);
    drain();
    new_txn(0, 1'b0, 32'h104, 32'h0, 4'b0011);
    drain();

    rnd = 1'b1;
    repeat (400) step();
    rnd = 1'b0;
    drain();

    // Reset while the read response is on the bus.
    new_txn(1, 1'b0, 32'h200, 32'h0, 4'hF);
    step();
    step();
    i_rst_n = 1'b0;
    #1;
    chk("async_rst_ctrl", 32'({bus.o_gnt, bus.o_rvalid, bus.o_mem_en, bus.o_mem_we,
                               bus.o_busy, bus.o_mem_bmask}), 32'h0);
    chk("async_rst_rdata", bus.o_rdata, 32'h0);
    chk("async_rst_wdata", bus.o_mem_wdata, 32'h0);
    gq.delete();
    rq.delete();
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    bus.i_req = '0;
    repeat (2) @(negedge i_clk);
    #1;
    i_rst_n = 1'b1;
    last_g  = 1;
    free_at = 0;
    new_txn(0, 1'b0, 32'h200, 32'h0, 4'hF);
    drain();

    chk("scoreboard_drained", 32'(gq.size() + rq.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports (clock and reset first):
  i_clk  in  1  clock, all state on rising edge
  i_rst_n  in  1  reset, asynchronous, active-low
  i_req  in  2  per-requester access request; bit0 = core LSU, bit1 = program loader
  i_we  in  2  per-requester write enable; 0 = read
  i_addr  in  2x32  per-requester byte address
  i_wdata  in  2x32  per-requester write data
  i_bmask  in  2x4  per-requester byte-lane mask
  o_gnt  out  2  one-hot, 1-cycle pulse; request consumed
  o_rvalid  out  2  one-hot, 1-cycle pulse; read data valid
  o_rdata  out  32  read data, valid with o_rvalid
  o_mem_en  out  1  memory access strobe
  o_mem_we  out  1  memory write
  o_mem_addr  out  32  memory address
  o_mem_wdata  out  32  memory write data
  o_mem_bmask  out  4  memory byte mask
  i_mem_rdata  in  32  memory read data, valid the cycle after o_mem_en with o_mem_we=0
  o_busy  out  1  arbiter not in IDLE

Function
REQ-002 SHALL implement FSM states IDLE, ACCESS, RSP.
REQ-003 In IDLE with any i_req bit set, SHALL pick a winner, register its we/addr/wdata/bmask, and go to ACCESS next cycle.
REQ-004 Arbitration SHALL be round-robin: single request wins outright; both requesting, the requester not granted last wins.
REQ-005 The last-granted pointer SHALL update only on an o_gnt pulse.
REQ-006 In ACCESS, SHALL assert o_mem_en and o_gnt[winner] for exactly one cycle, with o_mem_* driven from registered values.
REQ-007 From ACCESS, a write SHALL return to IDLE; a read SHALL go to RSP.
REQ-008 In RSP, SHALL drive o_rdata = i_mem_rdata and o_rvalid[winner]=1 for one cycle, then return to IDLE.
REQ-009 Latency: request seen in IDLE at cycle N -> o_gnt at N+1 -> read o_rvalid at N+2.
REQ-010 Throughput: max one write per 2 cycles and one read per 3 cycles.
REQ-011 Requesters SHALL hold i_req and payload stable until o_gnt. Changes after IDLE registers the payload SHALL have no effect on the current access.
REQ-012 Request withdrawn while the arbiter is outside IDLE SHALL be ignored; only i_req sampled in IDLE counts.
REQ-013 Starvation bound: a continuously asserted request SHALL be granted within 4 cycles (write) or 6 cycles (read) of first being sampled.
REQ-014 Outside ACCESS, o_mem_en and o_mem_we SHALL be 0. Outside RSP, o_rvalid SHALL be 0.
REQ-015 o_gnt and o_rvalid SHALL never have more than one bit set.
REQ-016 o_busy SHALL be 1 in ACCESS and RSP, 0 in IDLE.
REQ-017 i_bmask SHALL pass through unmodified for writes; reads SHALL drive o_mem_bmask=4'hF.

Reset
REQ-018 While i_rst_n=0, SHALL force asynchronously: state IDLE, last-granted pointer = requester 1 (so requester 0 wins the first tie), all outputs 0.
REQ-019 Reset asserted in ACCESS or RSP SHALL abort the transaction. No o_gnt or o_rvalid pulse for the aborted access SHALL appear after reset release.
REQ-020 First arbitration SHALL occur on the first rising edge with i_rst_n=1.

Structure
REQ-021 Package arb_pkg SHALL hold the FSM state enum, NUM_REQ=2, ADDR_W=32, DATA_W=32.
REQ-022 Winner selection SHALL be a combinational sub-module rr_picker (inputs: requests, last pointer; output: one-hot winner).

Verification
REQ-023 Single write: m0 we=1, addr=0x100, wdata=0xDEADBEEF, bmask=F -> o_gnt=01 and o_mem_en/we at N+1, addr/data match, no rvalid.
REQ-024 Single read: m1 read 0x100 with memory returning 0xDEADBEEF -> o_gnt=10 at N+1; o_rvalid=10 and o_rdata=0xDEADBEEF at N+2.
REQ-025 Tie after reset: both request reads continuously -> grant order 01,10,01,10; each rvalid matches its own grant.
REQ-026 Payload change: m0 changes addr 0x200->0x300 the cycle after IDLE samples it -> o_mem_addr=0x200.
REQ-027 Reset mid-read: assert i_rst_n=0 in RSP -> all outputs 0 immediately; after release, no stale o_rvalid; next request follows REQ-009 timing.
REQ-028 Byte write: m0 bmask=4'b0011 -> o_mem_bmask=0011; a following read drives o_mem_bmask=1111.
